rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables and selects for the program counter, instruction register, register file write port, ALU operand muxes and data-memory request handshake. It sits beside the top-level datapath and replaces the hard-tied jump, we and wdata controls there.

Parameters:
XLEN, 32, datapath/instruction width
ACK_TIMEOUT, 16, max MEM-state cycles waiting for mem_ack before trap; 0 = wait forever
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
run  in  1  start/continue execution
instr  in  XLEN  imem read data, valid the cycle after FETCH
br_taken  in  1  branch comparator result, valid in EXEC
mem_ack  in  1  data-memory completion
pc_en  out  1  PC update strobe
pc_sel  out  2  00 pc+4, 01 pc+imm (branch/JAL), 10 rs1+imm (JALR)
ir_we  out  1  instruction register capture
rf_we  out  1  register file write enable
wb_sel  out  2  00 ALU, 01 mem data, 10 pc+4, 11 imm (LUI)
alu_src  out  1  0 rs2, 1 immediate
imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J
mem_req  out  1  data-memory request, held until ack
mem_we  out  1  store qualifier for mem_req
state  out  3  current state encoding (debug)
instret_pulse  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky after ECALL/EBREAK
trap  out  1  sticky after fault
trap_cause  out  2  01 illegal opcode, 10 mem_ack timeout
cycle_cnt  out  CNT_W  cycle counter (optional)
instret_cnt  out  CNT_W  retired counter (optional)

Behaviour:
- Reset: state=IDLE; all outputs 0; latched opcode/rd, timeout counter and trap_cause cleared. Reset in any state, including mid-MEM, returns to IDLE at the next edge; mem_req drops then.
- Outputs are Moore: decoded from the current state plus the opcode/rd latched in DECODE.
- IDLE: run=1 -> FETCH.
- FETCH (1 cycle): PC presented to imem. -> DECODE.
- DECODE: ir_we=1. Latch instr[6:0] and instr[11:7].
  - Opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC.
  - 1110011 with instr[31:7]=0 (ECALL) or 0x002000 (EBREAK) -> HALT.
  - Any other value -> TRAP, cause 01.
- EXEC: alu_src and imm_sel follow the opcode (R: alu_src=0).
  - LOAD/STORE -> MEM.
  - BRANCH: pc_en=1, pc_sel = br_taken ? 01 : 00, instret_pulse=1; -> FETCH if run else IDLE.
  - Others -> WB.
- MEM: mem_req=1, mem_we=1 for STORE; the timeout counter increments each cycle.
  - Ack on the cycle it is sampled high: STORE retires (pc_en=1, pc_sel=00) -> FETCH/IDLE; LOAD -> WB.
  - Counter reaching ACK_TIMEOUT with no ack -> TRAP, cause 10.
  - The counter clears on MEM exit.
- WB: rf_we=1 unless latched rd=0. wb_sel: LOAD 01, JAL/JALR 10, LUI 11, else 00. pc_en=1; pc_sel JAL 01, JALR 10, else 00. instret_pulse=1. -> FETCH if run else IDLE.
- run deasserted mid-instruction: the instruction completes, then IDLE.
- HALT: halted=1, no enables, sticky until rst; run is ignored.
- TRAP: trap=1, trap_cause held, sticky until rst.
- Latency (no memory wait): R/I/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5. Each mem_ack wait cycle adds 1.

Optional Feature:
RV_CTRL_PERF_CNT_EN
- Defined: cycle_cnt increments every cycle state is not IDLE/HALT/TRAP; instret_cnt increments on instret_pulse. Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
1. rst, run=1, instr=0x00500093 (addi x1,x0,5) -> states IDLE,FETCH,DECODE,EXEC,WB; in WB rf_we=1, wb_sel=00, pc_en=1, pc_sel=00, instret_pulse=1; back to FETCH on cycle 5.
2. instr=0x0000A103 (lw x2,0(x1)), mem_ack on 3rd MEM cycle -> mem_req high exactly 3 cycles, mem_we=0, then WB with wb_sel=01, rf_we=1.
3. instr=0x00208463 (beq), br_taken=1 -> 3-cycle instruction; EXEC pc_en=1, pc_sel=01, imm_sel=2; rf_we never asserted. Repeat with br_taken=0 -> pc_sel=00.
4. instr=0x00000013 (addi x0) -> WB with rf_we=0, pc_en=1. Then run=0 during EXEC of the next instruction -> it completes, then IDLE.
5. instr=0xFFFFFFFF -> TRAP, trap=1, trap_cause=01, held 20 cycles. After rst, instr=0x00000073 -> halted=1, no pc_en.
6. sw with mem_ack held 0, ACK_TIMEOUT=16 -> trap_cause=10 after 16 MEM cycles. Separately, rst asserted in the 2nd MEM cycle -> IDLE and mem_req=0 at the next edge. With RV_CTRL_PERF_CNT_EN defined, after test 1 instret_cnt=1 and cycle_cnt=4.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - RV32I multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB)
// Optional performance counters enabled by defining RV_CTRL_PERF_CNT_EN.
module rv_multicycle_ctrl #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [XLEN-1:0]  instr,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [2:0]       imm_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic             instret_pulse,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Counter only has to reach ACK_TIMEOUT-1; the timeout fires while it sits there.
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t           cur;
  logic [6:0]       opc;
  logic [4:0]       rd;
  logic [TMO_W-1:0] tmo;
  logic [1:0]       cause;

  logic op_legal, op_halt;
  logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic tmo_hit;

  always_comb begin
    op_legal = 1'b0;
    unique case (instr[6:0])
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  // ECALL and EBREAK differ only in bit 20; any other SYSTEM encoding traps.
  assign op_halt = (instr[6:0] == OP_SYSTEM) &&
                   ((instr[XLEN-1:7] == '0) ||
                    (instr[XLEN-1:7] == (XLEN-7)'(25'h0002000)));

  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jal    = (opc == OP_JAL);
  assign is_jalr   = (opc == OP_JALR);
  assign is_lui    = (opc == OP_LUI);
  assign tmo_hit   = (ACK_TIMEOUT != 0) && (tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= S_IDLE;
      opc   <= '0;
      rd    <= '0;
      tmo   <= '0;
      cause <= '0;
    end else begin
      case (cur)
        S_IDLE: if (run) cur <= S_FETCH;
        S_FETCH: cur <= S_DECODE;
        S_DECODE: begin
          opc <= instr[6:0];
          rd  <= instr[11:7];
          if (op_legal) begin
            cur <= S_EXEC;
          end else if (op_halt) begin
            cur <= S_HALT;
          end else begin
            cur   <= S_TRAP;
            cause <= 2'b01;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) cur <= S_MEM;
          else if (is_branch)      cur <= run ? S_FETCH : S_IDLE;
          else                     cur <= S_WB;
        end
        S_MEM: begin
          if (mem_ack) begin
            tmo <= '0;
            cur <= is_store ? (run ? S_FETCH : S_IDLE) : S_WB;
          end else if (tmo_hit) begin
            tmo   <= '0;
            cur   <= S_TRAP;
            cause <= 2'b10;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        S_WB: cur <= run ? S_FETCH : S_IDLE;
        S_HALT, S_TRAP: cur <= cur;
        default: cur <= S_IDLE;
      endcase
    end
  end

  // Operand selects stay valid through MEM/WB so the datapath can reuse the immediate.
  always_comb begin
    pc_en         = 1'b0;
    pc_sel        = 2'b00;
    ir_we         = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 2'b00;
    alu_src       = 1'b0;
    imm_sel       = IMM_I;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    instret_pulse = 1'b0;
    halted        = 1'b0;
    trap          = 1'b0;
    if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
      case (opc)
        OP_R:             begin alu_src = 1'b0; imm_sel = IMM_I; end
        OP_STORE:         begin alu_src = 1'b1; imm_sel = IMM_S; end
        OP_BRANCH:        begin alu_src = 1'b0; imm_sel = IMM_B; end
        OP_LUI, OP_AUIPC: begin alu_src = 1'b1; imm_sel = IMM_U; end
        OP_JAL:           begin alu_src = 1'b1; imm_sel = IMM_J; end
        default:          begin alu_src = 1'b1; imm_sel = IMM_I; end
      endcase
    end
    case (cur)
      S_DECODE: ir_we = 1'b1;
      S_EXEC: begin
        if (is_branch) begin
          pc_en         = 1'b1;
          pc_sel        = br_taken ? 2'b01 : 2'b00;
          instret_pulse = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack && is_store) begin
          pc_en         = 1'b1;
          instret_pulse = 1'b1;
        end
      end
      S_WB: begin
        rf_we         = (rd != 5'd0);
        pc_en         = 1'b1;
        instret_pulse = 1'b1;
        if (is_load)                 wb_sel = 2'b01;
        else if (is_jal || is_jalr)  wb_sel = 2'b10;
        else if (is_lui)             wb_sel = 2'b11;
        if (is_jal)       pc_sel = 2'b01;
        else if (is_jalr) pc_sel = 2'b10;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: trap   = 1'b1;
      default: ;
    endcase
  end

  assign state      = cur;
  assign trap_cause = cause;

`ifdef RV_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (cur != S_IDLE && cur != S_HALT && cur != S_TRAP) cyc_q <= cyc_q + CNT_W'(1);
      if (instret_pulse) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - directed-vector bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;
  localparam int XLEN = 32;
  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst, run, br_taken, mem_ack;
  logic [XLEN-1:0] instr;
  logic pc_en, ir_we, rf_we, alu_src, mem_req, mem_we, instret_pulse, halted, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [2:0] imm_sel, state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [17:0] ctl;

  rv_multicycle_ctrl #(.XLEN(XLEN), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .br_taken(br_taken), .mem_ack(mem_ack),
    .pc_en(pc_en), .pc_sel(pc_sel), .ir_we(ir_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_src(alu_src), .imm_sel(imm_sel), .mem_req(mem_req), .mem_we(mem_we), .state(state),
    .instret_pulse(instret_pulse), .halted(halted), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  assign ctl = {pc_en, pc_sel, ir_we, rf_we, wb_sel, alu_src, imm_sel,
                mem_req, mem_we, instret_pulse, halted, trap, trap_cause};

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered in FETCH; runs one non-memory, non-branch instruction through WB and back to FETCH.
  task automatic run_alu(input string nm, input logic [31:0] iw, input int e_imm, input int e_alu,
                         input int e_wb, input int e_pcsel, input int e_rfwe);
    instr = iw;
    tick();
    check({nm, ".dec_state"}, 32'(state), 2);
    check({nm, ".ir_we"}, 32'(ir_we), 1);
    tick();
    check({nm, ".exec_state"}, 32'(state), 3);
    check({nm, ".exec_alu_src"}, 32'(alu_src), 32'(e_alu));
    check({nm, ".exec_imm_sel"}, 32'(imm_sel), 32'(e_imm));
    check({nm, ".exec_pc_en"}, 32'(pc_en), 0);
    tick();
    check({nm, ".wb_state"}, 32'(state), 5);
    check({nm, ".rf_we"}, 32'(rf_we), 32'(e_rfwe));
    check({nm, ".wb_sel"}, 32'(wb_sel), 32'(e_wb));
    check({nm, ".pc_en"}, 32'(pc_en), 1);
    check({nm, ".pc_sel"}, 32'(pc_sel), 32'(e_pcsel));
    check({nm, ".imm_sel_wb"}, 32'(imm_sel), 32'(e_imm));
    check({nm, ".instret"}, 32'(instret_pulse), 1);
    tick();
    check({nm, ".next_fetch"}, 32'(state), 1);
  endtask

  int bad;

  initial begin
    rst = 1'b1; run = 1'b0; instr = '0; br_taken = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_ctl", 32'(ctl), 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_instret_cnt", instret_cnt, 0);

    // addi x1,x0,5
    rst = 1'b0; run = 1'b1; instr = 32'h00500093;
    tick();
    check("t1_fetch", 32'(state), 1);
    check("t1_fetch_ir_we", 32'(ir_we), 0);
    run_alu("t1_addi", 32'h00500093, 0, 1, 0, 0, 1);
`ifdef RV_CTRL_PERF_CNT_EN
    check("perf_cycle_cnt", cycle_cnt, 4);
    check("perf_instret_cnt", instret_cnt, 1);
`else
    check("perf_cycle_cnt_off", cycle_cnt, 0);
    check("perf_instret_cnt_off", instret_cnt, 0);
`endif

    // lw x2,0(x1), ack on 3rd MEM cycle
    instr = 32'h0000A103;
    tick(); tick();
    check("ld_exec_state", 32'(state), 3);
    check("ld_exec_mem_req", 32'(mem_req), 0);
    tick();
    check("ld_mem1_req", 32'(mem_req), 1);
    check("ld_mem1_we", 32'(mem_we), 0);
    tick();
    check("ld_mem2_req", 32'(mem_req), 1);
    tick();
    mem_ack = 1'b1; #1;
    check("ld_mem3_state", 32'(state), 4);
    check("ld_mem3_req", 32'(mem_req), 1);
    check("ld_mem3_pc_en", 32'(pc_en), 0);
    tick();
    mem_ack = 1'b0; #1;
    check("ld_wb_state", 32'(state), 5);
    check("ld_wb_mem_req", 32'(mem_req), 0);
    check("ld_wb_sel", 32'(wb_sel), 1);
    check("ld_wb_rf_we", 32'(rf_we), 1);
    tick();
    check("ld_next_fetch", 32'(state), 1);

    // beq taken, then not taken
    br_taken = 1'b1; instr = 32'h00208463;
    tick(); tick();
    check("beq_t_state", 32'(state), 3);
    check("beq_t_pc_en", 32'(pc_en), 1);
    check("beq_t_pc_sel", 32'(pc_sel), 1);
    check("beq_t_imm_sel", 32'(imm_sel), 2);
    check("beq_t_rf_we", 32'(rf_we), 0);
    check("beq_t_instret", 32'(instret_pulse), 1);
    tick();
    check("beq_t_fetch", 32'(state), 1);
    br_taken = 1'b0;
    tick(); tick();
    check("beq_n_pc_en", 32'(pc_en), 1);
    check("beq_n_pc_sel", 32'(pc_sel), 0);
    tick();
    check("beq_n_fetch", 32'(state), 1);

    run_alu("jal", 32'h008000EF, 4, 1, 2, 1, 1);
    run_alu("jalr", 32'h000080E7, 0, 1, 2, 2, 1);
    run_alu("lui", 32'h123450B7, 3, 1, 3, 0, 1);
    run_alu("add", 32'h002081B3, 0, 0, 0, 0, 1);
    run_alu("addi_x0", 32'h00000013, 0, 1, 0, 0, 0);

    // run dropped during EXEC: instruction finishes, then IDLE
    instr = 32'h00100093;
    tick(); tick();
    run = 1'b0;
    tick();
    check("stop_wb_state", 32'(state), 5);
    check("stop_wb_pc_en", 32'(pc_en), 1);
    tick();
    check("stop_idle", 32'(state), 0);
    tick();
    check("stop_idle_hold", 32'(state), 0);

    // sw with immediate ack retires from MEM
    run = 1'b1; instr = 32'h0020A023;
    tick(); tick(); tick();
    check("sw_exec_imm_sel", 32'(imm_sel), 1);
    tick();
    mem_ack = 1'b1; run = 1'b0; #1;
    check("sw_mem_req", 32'(mem_req), 1);
    check("sw_mem_we", 32'(mem_we), 1);
    check("sw_pc_en", 32'(pc_en), 1);
    check("sw_pc_sel", 32'(pc_sel), 0);
    check("sw_instret", 32'(instret_pulse), 1);
    tick();
    mem_ack = 1'b0;
    check("sw_idle", 32'(state), 0);

    // illegal opcode
    run = 1'b1; instr = 32'hFFFFFFFF;
    tick(); tick(); tick();
    check("ill_state", 32'(state), 7);
    check("ill_trap", 32'(trap), 1);
    check("ill_cause", 32'(trap_cause), 1);
    check("ill_halted", 32'(halted), 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'b01 || pc_en !== 1'b0) bad++;
    end
    check("ill_sticky", 32'(bad), 0);

    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_state", 32'(state), 0);
    check("rst2_ctl", 32'(ctl), 0);

    // ECALL
    instr = 32'h00000073;
    tick(); tick(); tick();
    check("ecall_state", 32'(state), 6);
    check("ecall_halted", 32'(halted), 1);
    check("ecall_pc_en", 32'(pc_en), 0);
    repeat (5) tick();
    check("ecall_sticky", 32'(state), 6);

    // EBREAK
    rst = 1'b1; tick(); rst = 1'b0;
    instr = 32'h00100073;
    tick(); tick(); tick();
    check("ebreak_halted", 32'(halted), 1);

    // SYSTEM opcode that is neither ECALL nor EBREAK
    rst = 1'b1; tick(); rst = 1'b0;
    instr = 32'h00200073;
    tick(); tick(); tick();
    check("sys_bad_cause", 32'(trap_cause), 1);

    // sw with no ack: timeout after 16 MEM cycles
    rst = 1'b1; tick(); rst = 1'b0;
    instr = 32'h0020A023;
    tick(); tick(); tick(); tick();
    check("tmo_mem1", 32'(state), 4);
    check("tmo_mem1_we", 32'(mem_we), 1);
    bad = 0;
    repeat (ACK_TIMEOUT - 1) begin
      tick();
      if (state !== 3'd4 || mem_req !== 1'b1) bad++;
    end
    check("tmo_wait", 32'(bad), 0);
    tick();
    check("tmo_state", 32'(state), 7);
    check("tmo_cause", 32'(trap_cause), 2);
    check("tmo_mem_req", 32'(mem_req), 0);

    // reset in 2nd MEM cycle
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst3_cause", 32'(trap_cause), 0);
    tick(); tick(); tick(); tick();
    tick();
    rst = 1'b1; #1;
    check("mrst_mem2_req", 32'(mem_req), 1);
    tick();
    rst = 1'b0;
    check("mrst_state", 32'(state), 0);
    check("mrst_mem_req", 32'(mem_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
